// File: rtl/ncl_pkg.sv
// Shared dual-rail encoding constants, FSM state type and per-pair rail helpers
// for the NCL operand injector.
package ncl_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        NULL_WAIT
    } state_t;

    function automatic logic [1:0] dr_encode(input logic bits);
        return bits ? DR_ONE : DR_ZERO;
    endfunction

    // True rail of a DATA pair; callers only decode words already known to be DATA.
    function automatic logic dr_decode(input logic [1:0] pairs);
        return pairs == DR_ONE;
    endfunction

    function automatic logic dr_is_data(input logic [1:0] word);
        return word[1] ^ word[0];
    endfunction

    function automatic logic dr_is_null(input logic [1:0] word);
        return word == DR_NULL;
    endfunction

    function automatic logic dr_is_illegal(input logic [1:0] word);
        return word == 2'b11;
    endfunction

endpackage

// File: rtl/ncl_completion_sync.sv
// Synchronizes the dual-rail result, then flags all-DATA / all-NULL (and, with
// NCL_ILLEGAL_CHK_EN defined, persistent 11 pairs) over two consecutive samples.
module ncl_completion_sync
    import ncl_pkg::*;
#(
    parameter int PAIRS       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*PAIRS-1:0] dr_res,
    output logic               all_data,
    output logic               all_null,
    output logic               illegal,
    output logic [PAIRS-1:0]   res_bits
);

    logic [SYNC_STAGES-1:0][2*PAIRS-1:0] sync_q;
    logic [2*PAIRS-1:0]                  stab_q;
    logic [SYNC_STAGES:0]                fill_q;
    logic [2*PAIRS-1:0]                  cur;

    assign cur = sync_q[SYNC_STAGES-1];

    // NOTE: the rail flops carry no reset; fill_q qualifies them instead, so
    // stale or unknown samples can never count as complete after reset.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], dr_res};
        stab_q <= cur;
    end

    always_ff @(posedge clk) begin
        if (rst) fill_q <= '0;
        else     fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        all_data = fill_q[SYNC_STAGES];
        all_null = fill_q[SYNC_STAGES];
        res_bits = '0;
        for (int i = 0; i < PAIRS; i++) begin
            all_data &= dr_is_data(cur[2*i +: 2]) & dr_is_data(stab_q[2*i +: 2]);
            all_null &= dr_is_null(cur[2*i +: 2]) & dr_is_null(stab_q[2*i +: 2]);
            res_bits[i] = dr_decode(stab_q[2*i +: 2]);
        end
    end

`ifdef NCL_ILLEGAL_CHK_EN
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < PAIRS; i++) begin
            illegal |= dr_is_illegal(cur[2*i +: 2]) & dr_is_illegal(stab_q[2*i +: 2]);
        end
        illegal &= fill_q[SYNC_STAGES];
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/ncl_op_injector.sv
// Clocked front end of the dual-rail NCL ALU: issues DATA/NULL wavefronts and
// captures the completed result. NCL_ILLEGAL_CHK_EN enables the sticky err flag.
module ncl_op_injector
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_sub,
    output logic [2*WIDTH-1:0]   dr_a,
    output logic [2*WIDTH-1:0]   dr_b,
    output logic [1:0]           dr_sub,
    input  logic [2*WIDTH+1:0]   dr_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_res,
    output logic                 out_cout,
    output logic                 err
);

    localparam int PAIRS = WIDTH + 1;

    state_t             state, state_next;
    logic               accept, capture;
    logic               all_data, all_null, illegal;
    logic [PAIRS-1:0]   res_bits;
    logic [2*WIDTH-1:0] enc_a, enc_b;

    ncl_completion_sync #(
        .PAIRS       (PAIRS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .dr_res   (dr_res),
        .all_data (all_data),
        .all_null (all_null),
        .illegal  (illegal),
        .res_bits (res_bits)
    );

    always_comb begin
        enc_a = '0;
        enc_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enc_a[2*i +: 2] = dr_encode(in_a[i]);
            enc_b[2*i +: 2] = dr_encode(in_b[i]);
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                // A full output register that is not being popped holds the core in DATA.
                if (all_data && (!out_valid || out_ready)) begin
                    capture    = 1'b1;
                    state_next = NULL_WAIT;
                end
            end
            NULL_WAIT: begin
                if (all_null) state_next = IDLE;
            end
            default: state_next = NULL_WAIT;
        endcase
    end

    assign in_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NULL_WAIT;
            dr_a      <= '0;
            dr_b      <= '0;
            dr_sub    <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_cout  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                dr_a   <= enc_a;
                dr_b   <= enc_b;
                dr_sub <= dr_encode(in_sub);
            end else if (capture) begin
                dr_a   <= '0;
                dr_b   <= '0;
                dr_sub <= DR_NULL;
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_res   <= res_bits[WIDTH-1:0];
                out_cout  <= res_bits[WIDTH];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NCL_ILLEGAL_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (illegal) err <= 1'b1;
    end
`else
    // illegal is a constant 0 from the sync block in this build.
    assign err = illegal;
`endif

endmodule

// File: tb/tb_ncl_op_injector.sv
// Directed bench for ncl_op_injector with a zero-delay behavioural NCL adder,
// plus skew, hold and illegal-pair knobs on the returned result.
module tb_ncl_op_injector;

    localparam int WIDTH = 4;
    localparam int PAIRS = WIDTH + 1;
`ifdef NCL_ILLEGAL_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                 clk, rst;
    logic                 in_valid, in_ready, in_sub;
    logic [WIDTH-1:0]     in_a, in_b;
    logic [2*WIDTH-1:0]   dr_a, dr_b;
    logic [1:0]           dr_sub;
    logic [2*PAIRS-1:0]   dr_res;
    logic                 out_valid, out_ready, out_cout, err;
    logic [WIDTH-1:0]     out_res;

    // datapath model knobs
    logic [PAIRS-1:0]     pair_en;
    logic                 hold, force_ill;
    logic [2*PAIRS-1:0]   held, model;
    logic [WIDTH-1:0]     va, vb;
    logic [WIDTH:0]       sum;
    logic                 ok;

    int n_checks = 0;
    int n_errors = 0;

    ncl_op_injector #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .dr_a      (dr_a),
        .dr_b      (dr_b),
        .dr_sub    (dr_sub),
        .dr_res    (dr_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cout  (out_cout),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        ok = 1'b1;
        va = '0;
        vb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ok &= (dr_a[2*i+1] ^ dr_a[2*i]) & (dr_b[2*i+1] ^ dr_b[2*i]);
            va[i] = dr_a[2*i+1];
            vb[i] = dr_b[2*i+1];
        end
        ok &= dr_sub[1] ^ dr_sub[0];
        sum = {1'b0, va} + (dr_sub[1] ? {1'b0, ~vb} : {1'b0, vb}) + {{WIDTH{1'b0}}, dr_sub[1]};
        model = '0;
        for (int i = 0; i < PAIRS; i++) begin
            if (ok && pair_en[i]) model[2*i +: 2] = sum[i] ? 2'b10 : 2'b01;
        end
        dr_res = hold ? held : model;
        if (force_ill) dr_res[5:4] = 2'b11;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            tick();
            n++;
        end
        check("wait_in_ready", in_ready, 1);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        wait_ready(40);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_a     = 4'hf;
        in_b     = 4'hf;
        in_sub   = ~sub;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b0; pair_en = '1; hold = 1'b0; force_ill = 1'b0; held = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state and NULL confirmation delay
        check("rst_dr_a", dr_a, 0);
        check("rst_dr_b", dr_b, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_err", err, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rst_in_ready_low", in_ready, 0);
        end
        tick();
        check("rst_in_ready_high", in_ready, 1);

        // 2: subtract 0101 - 0011
        issue(4'b0101, 4'b0011, 1'b1);
        check("sub_dr_a", dr_a, 8'b01100110);
        check("sub_dr_b", dr_b, 8'b01011010);
        check("sub_dr_sub", dr_sub, 2'b10);
        check("sub_in_ready_busy", in_ready, 0);
        tick(); tick(); tick();
        check("sub_no_early_valid", out_valid, 0);
        tick();
        check("sub_out_valid", out_valid, 1);
        check("sub_out_res", out_res, 4'b0010);
        check("sub_out_cout", out_cout, 1);
        check("sub_dr_a_null", dr_a, 0);
        check("sub_dr_sub_null", dr_sub, 0);
        tick(); tick(); tick();
        check("sub_in_ready_e7", in_ready, 0);
        tick();
        check("sub_in_ready_e8", in_ready, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sub_pop", out_valid, 0);

        // 3: skewed completion, 0111 + 0001, last pair valid after E3
        pair_en = 5'b00001;
        issue(4'b0111, 4'b0001, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            pair_en[k] = 1'b1;
            tick();
            check("skew_no_capture", out_valid, 0);
        end
        tick();
        check("skew_no_capture_e5", out_valid, 0);
        tick();
        check("skew_no_capture_e6", out_valid, 0);
        tick();
        check("skew_capture_e7", out_valid, 1);
        check("skew_out_res", out_res, 4'b1000);
        check("skew_out_cout", out_cout, 0);

        // 4: backpressure, result register still full with 1000
        issue(4'b1001, 4'b0100, 1'b0);
        check("bp_dr_a", dr_a, 8'b10010110);
        for (int k = 0; k < 8; k++) tick();
        check("bp_hold_dr_a", dr_a, 8'b10010110);
        check("bp_in_ready", in_ready, 0);
        check("bp_old_valid", out_valid, 1);
        check("bp_old_res", out_res, 4'b1000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_pop_capture_valid", out_valid, 1);
        check("bp_new_res", out_res, 4'b1101);
        check("bp_new_cout", out_cout, 0);
        check("bp_dr_a_null", dr_a, 0);

        // 5: reset while in DATA with the core holding its result
        issue(4'b0010, 4'b0001, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        check("mid_in_data", dr_a, 8'b01011001);
        held = dr_res;
        hold = 1'b1;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        check("mid_rst_dr_a", dr_a, 0);
        check("mid_rst_dr_b", dr_b, 0);
        check("mid_rst_dr_sub", dr_sub, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_core_held", in_ready, 0);
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_null_confirm", in_ready, 0);
        end
        tick();
        check("mid_ready_after_null", in_ready, 1);

        // 6: illegal pair 2 reads 11
        force_ill = 1'b1;
        issue(4'b0001, 4'b0001, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        check("ill_no_capture", out_valid, 0);
        check("ill_stuck_data", in_ready, 0);
        check("ill_err", err, EXP_ERR);
        force_ill = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("ill_cleared_capture", out_valid, 1);
        check("ill_cleared_res", out_res, 4'b0010);
        check("ill_err_sticky", err, EXP_ERR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ill_err_rst", err, 0);
        check("ill_rst_out_valid", out_valid, 0);
        wait_ready(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
